// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller bus between the pipeline datapath and the sequencing controller
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic [4:0]       Ex_Rw;
  logic             Ex_RegWr;
  logic             Ex_MemtoReg;
  logic             Branch_Taken;
  logic             Mem_Req;
  logic             Mem_Ready;
  logic             PC_En;
  logic             IFID_En;
  logic             IDEX_En;
  logic             EXMEM_En;
  logic             MEMWR_En;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             MemWr_Bubble;
  logic             Mem_Err;
  logic [CNT_W-1:0] Stall_Cnt;
  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, Ex_Rw, Ex_RegWr, Ex_MemtoReg, Branch_Taken, Mem_Req, Mem_Ready,
    input  PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWR_En, IFID_Flush, IDEX_Flush, MemWr_Bubble, Mem_Err, Stall_Cnt
  );
  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, Ex_Rw, Ex_RegWr, Ex_MemtoReg, Branch_Taken, Mem_Req, Mem_Ready,
    output PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWR_En, IFID_Flush, IDEX_Flush, MemWr_Bubble, Mem_Err, Stall_Cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: five-stage pipeline sequencing for load-use stalls, taken branches and memory freezes
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic               Clk,
  input logic               Rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  typedef enum logic {RUN, MEMWAIT} state_t;
  state_t           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu, frz;
  // hazard and freeze conditions seen by the current cycle
  always_comb begin
    lu  = bus.Ex_MemtoReg & bus.Ex_RegWr & (bus.Ex_Rw != 5'd0) &
          ((bus.Ex_Rw == bus.ID_Rs) | (bus.ID_UsesRt & (bus.Ex_Rw == bus.ID_Rt)));
    frz = (state_q == RUN) ? (bus.Mem_Req & ~bus.Mem_Ready) : ~bus.Mem_Ready;
  end
  // state register plus wait counter, error pulse and stall counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  // next state: enter the wait on a freeze, leave on ready or after the timeout
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = 1'b0;
    if (state_q == RUN) begin
      if (frz) begin
        state_d = MEMWAIT;
        wcnt_d  = WW'(1);
      end
    end else if (bus.Mem_Ready) begin
      state_d = RUN;
      wcnt_d  = '0;
    end else if (wcnt_q == TMO) begin
      state_d   = RUN;
      wcnt_d    = '0;
      mem_err_d = 1'b1;
    end else begin
      wcnt_d = wcnt_q + WW'(1);
    end
    stall_cnt_d = (!bus.PC_En && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  // stage controls: freeze beats branch, branch beats load-use (wrong-path instruction)
  always_comb begin
    bus.PC_En        = ~Rst & ~frz & (bus.Branch_Taken | ~lu);
    bus.IFID_En      = ~Rst & ~frz & (bus.Branch_Taken | ~lu);
    bus.IDEX_En      = ~Rst & ~frz;
    bus.EXMEM_En     = ~Rst & ~frz;
    bus.MEMWR_En     = ~Rst;
    bus.IFID_Flush   = Rst | (~frz & bus.Branch_Taken);
    bus.IDEX_Flush   = Rst | (~frz & (bus.Branch_Taken | lu));
    bus.MemWr_Bubble = Rst | frz;
    bus.Mem_Err      = mem_err_q;
    bus.Stall_Cnt    = stall_cnt_q;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized check of pipe_hazard_ctrl against an access-level model
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int SMAX    = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   streak = 0;
  bit   err_q = 1'b0;
  int   sc = 0;
  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.Clk(clk), .Rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // expected {PC,IFID,IDEX,EXMEM,MEMWR enables, IFID flush, IDEX flush, bubble} for a pipeline action
  function automatic logic [7:0] action(input bit r, input bit f, input bit br, input bit l);
    if (r)  return 8'b00000_111;
    if (f)  return 8'b00001_001;
    if (br) return 8'b11111_110;
    if (l)  return 8'b00111_010;
    return 8'b11111_000;
  endfunction
  task automatic drive(input bit r, input int rs, input int rt, input bit ut, input int rw,
                       input bit rwr, input bit m2r, input bit br, input bit req, input bit rdy);
    rst              = r;
    bus.ID_Rs        = 5'(rs);
    bus.ID_Rt        = 5'(rt);
    bus.ID_UsesRt    = ut;
    bus.Ex_Rw        = 5'(rw);
    bus.Ex_RegWr     = rwr;
    bus.Ex_MemtoReg  = m2r;
    bus.Branch_Taken = br;
    bus.Mem_Req      = req;
    bus.Mem_Ready    = rdy;
  endtask
  task automatic step(input string tag);
    bit l, f, nerr;
    logic [7:0] e, got;
    @(negedge clk);
    if (rst) begin
      streak = 0;
      err_q  = 1'b0;
      sc     = 0;
    end
    l = bus.Ex_MemtoReg && bus.Ex_RegWr && bus.Ex_Rw != 0 &&
        (bus.Ex_Rw == bus.ID_Rs || (bus.ID_UsesRt && bus.Ex_Rw == bus.ID_Rt));
    f = !rst && (streak > 0 || bus.Mem_Req) && !bus.Mem_Ready;
    e = action(rst, f, bus.Branch_Taken, l);
    got = {bus.PC_En, bus.IFID_En, bus.IDEX_En, bus.EXMEM_En, bus.MEMWR_En,
           bus.IFID_Flush, bus.IDEX_Flush, bus.MemWr_Bubble};
    chk({tag, "_ctl"}, 32'(got), 32'(e));
    chk({tag, "_err"}, 32'(bus.Mem_Err), 32'(err_q));
    chk({tag, "_cnt"}, 32'(bus.Stall_Cnt), 32'(sc));
    nerr = 1'b0;
    if (!rst) begin
      if (f) begin
        streak++;
        if (streak == TIMEOUT + 1) begin
          nerr   = 1'b1;
          streak = 0;
        end
      end else begin
        streak = 0;
      end
      if (!e[7] && sc < SMAX) sc++;
    end
    err_q = nerr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst");
    step("rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle");
    step("idle");
    drive(0, 5, 0, 0, 5, 1, 1, 0, 0, 0);
    step("lu");
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_after");
    chk("lu_cnt1", 32'(bus.Stall_Cnt), 32'd1);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("lu_r0");
    drive(0, 3, 7, 1, 7, 1, 1, 0, 0, 0);
    step("lu_rt");
    drive(0, 3, 7, 1, 7, 1, 1, 1, 0, 0);
    step("br_lu");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("mw");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mw_rdy");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mw_idle");
    chk("mw_cnt3", 32'(bus.Stall_Cnt), 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("zw");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step("tmo");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("tmo_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat15", 32'(bus.Stall_Cnt), 32'd15);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst");
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 1));
      step("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
